// File: rtl/alu_seq_pkg.sv
// Shared types and control constants for the ALU operation sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;

    localparam logic [3:0] CTL_NONE = 4'hF;
    localparam logic [3:0] OUT_A    = 4'd0;
    localparam logic [3:0] OUT_ALU  = 4'd2;
    localparam logic [3:0] LD_A     = 4'd0;
    localparam logic [3:0] LD_B     = 4'd1;
    localparam logic [2:0] OP_IDLE  = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        READ   = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Command fields that must survive past the accept edge.
    typedef struct packed {
        logic [2:0]        op;
        logic [1:0]        sel_l;
        logic              cin;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef struct packed {
        logic [3:0]        outctl;
        logic [3:0]        loadctl;
        logic [1:0]        arg_l;
        logic [2:0]        arg_r;
        logic              calcfn;
        logic              cin;
        logic              bus_oe;
        logic [DATA_W-1:0] bus_data;
    } ctl_t;

    localparam ctl_t CTL_IDLE_WORD = '{
        outctl:   CTL_NONE,
        loadctl:  CTL_NONE,
        arg_l:    2'd0,
        arg_r:    OP_IDLE,
        calcfn:   1'b0,
        cin:      1'b0,
        bus_oe:   1'b0,
        bus_data: '0
    };

endpackage

// File: rtl/alu_seq_decode.sv
// Decodes the next state plus command fields into the ALU control word.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  state_t state_nxt,
    input  cmd_t   cmd,
    output ctl_t   ctl
);

    always_comb begin
        ctl = CTL_IDLE_WORD;
        case (state_nxt)
            LOAD_A: begin
                ctl.loadctl  = LD_A;
                ctl.bus_oe   = 1'b1;
                ctl.bus_data = cmd.a;
            end
            LOAD_B: begin
                ctl.loadctl  = LD_B;
                ctl.bus_oe   = 1'b1;
                ctl.bus_data = cmd.b;
            end
            // ALU result goes out on the bus and straight back into A.
            CALC: begin
                ctl.outctl  = OUT_ALU;
                ctl.loadctl = LD_A;
                ctl.arg_r   = cmd.op;
                ctl.arg_l   = cmd.sel_l;
                ctl.cin     = cmd.cin;
                ctl.calcfn  = 1'b1;
            end
            READ: begin
                ctl.outctl = OUT_A;
            end
            default: ctl = CTL_IDLE_WORD;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences alu_block through load A, load B, compute, read-back for one command at a time.
// Latency: accept to res_valid 5 cycles (4 with use_acc, 1 for reserved op).
// Backpressure: one command in flight; result held stable until res_ready, cmd_ready low while busy.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_sel_l,
    input  logic        cmd_cin,
    input  logic        cmd_use_acc,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [3:0]  outctl,
    output logic [3:0]  loadctl,
    output logic [1:0]  arg_l,
    output logic [2:0]  arg_r,
    output logic        calcfn,
    output logic        cin,
    output logic        bus_oe,
    output logic [7:0]  bus_data,
    input  logic [7:0]  main_bus,
    input  logic [3:0]  fout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [3:0]  res_flags,
    output logic        res_err,
    output logic        busy
);

    state_t state_q;
    state_t state_d;
    cmd_t   cmd_q;
    cmd_t   cmd_in;
    cmd_t   cmd_d;
    ctl_t   ctl_d;
    ctl_t   ctl_q;
    logic   accept;
    logic   res_hs;

    assign accept = cmd_valid & cmd_ready;
    assign res_hs = res_valid & res_ready;

    always_comb begin
        cmd_in       = '0;
        cmd_in.op    = cmd_op;
        cmd_in.sel_l = cmd_sel_l;
        cmd_in.cin   = cmd_cin;
        cmd_in.a     = cmd_a;
        cmd_in.b     = cmd_b;
    end

    // The decoder sees the incoming fields on the accept edge so LOAD_A is correct in its first cycle.
    assign cmd_d = accept ? cmd_in : cmd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_IDLE) begin
                        state_d = DONE;
                    end else if (cmd_use_acc) begin
                        state_d = LOAD_B;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = CALC;
            CALC:    state_d = READ;
            READ:    state_d = DONE;
            DONE:    state_d = res_hs ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    alu_seq_decode u_decode (
        .state_nxt (state_d),
        .cmd       (cmd_d),
        .ctl       (ctl_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q     <= '0;
            ctl_q     <= CTL_IDLE_WORD;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= cmd_in;
            end
            ctl_q     <= ctl_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            res_valid <= (state_d == DONE);
        end
    end

    // Result register: cleared on accept, loaded as READ ends, cleared again after handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data  <= '0;
            res_flags <= '0;
            res_err   <= 1'b0;
        end else if (accept) begin
            res_data  <= '0;
            res_flags <= '0;
            res_err   <= (cmd_op == OP_IDLE);
        end else if (state_q == READ) begin
            res_data  <= main_bus;
            res_flags <= fout;
            res_err   <= 1'b0;
        end else if (state_q == DONE && res_hs) begin
            res_data  <= '0;
            res_flags <= '0;
            res_err   <= 1'b0;
        end
    end

    assign outctl   = ctl_q.outctl;
    assign loadctl  = ctl_q.loadctl;
    assign arg_l    = ctl_q.arg_l;
    assign arg_r    = ctl_q.arg_r;
    assign calcfn   = ctl_q.calcfn;
    assign cin      = ctl_q.cin;
    assign bus_oe   = ctl_q.bus_oe;
    assign bus_data = ctl_q.bus_data;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: behavioural ALU environment plus a transaction-level expectation model.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_sel_l;
    logic       cmd_cin;
    logic       cmd_use_acc;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] outctl;
    logic [3:0] loadctl;
    logic [1:0] arg_l;
    logic [2:0] arg_r;
    logic       calcfn;
    logic       cin;
    logic       bus_oe;
    logic [7:0] bus_data;
    logic [7:0] main_bus;
    logic [3:0] fout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic       res_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] acc;
    logic       acc_valid;

    localparam int PH_LA   = 0;
    localparam int PH_LB   = 1;
    localparam int PH_CALC = 2;
    localparam int PH_READ = 3;
    localparam int PH_IDLE = 4;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_sel_l   (cmd_sel_l),
        .cmd_cin     (cmd_cin),
        .cmd_use_acc (cmd_use_acc),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .outctl      (outctl),
        .loadctl     (loadctl),
        .arg_l       (arg_l),
        .arg_r       (arg_r),
        .calcfn      (calcfn),
        .cin         (cin),
        .bus_oe      (bus_oe),
        .bus_data    (bus_data),
        .main_bus    (main_bus),
        .fout        (fout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_flags   (res_flags),
        .res_err     (res_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU arithmetic: returns {N, Z, C, V, result}.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] l,
                                            input logic [7:0] r, input logic ci);
        logic [8:0] s;
        logic [7:0] y;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        y = l;
        s = '0;
        case (op)
            3'd1: begin
                s = {1'b0, l} + {1'b0, r} + {8'd0, ci};
                y = s[7:0];
                c = s[8];
                v = (l[7] == r[7]) && (y[7] != l[7]);
            end
            3'd2: begin
                s = {1'b0, l} + {1'b0, ~r} + {8'd0, ~ci};
                y = s[7:0];
                c = s[8];
                v = (l[7] != r[7]) && (y[7] != l[7]);
            end
            3'd3: y = l & r;
            3'd4: y = l | r;
            3'd5: y = l ^ r;
            default: y = l;
        endcase
        return {y[7], (y == 8'd0), c, v, y};
    endfunction

    // Behavioural stand-in for alu_block driven by the sequencer's control lines.
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_f;
    logic [7:0]  alu_left;
    logic [11:0] alu_out;

    always_comb begin
        case (arg_l)
            2'd0:    alu_left = alu_a;
            2'd1:    alu_left = alu_b;
            2'd2:    alu_left = 8'h00;
            default: alu_left = 8'hFF;
        endcase
    end

    assign alu_out = alu_ref(arg_r, alu_left, alu_b, cin);

    always_comb begin
        if (bus_oe)
            main_bus = bus_data;
        else if (outctl == 4'd0)
            main_bus = alu_a;
        else if (outctl == 4'd2)
            main_bus = alu_out[7:0];
        else
            main_bus = 8'h00;
    end

    assign fout = alu_f;

    always @(posedge clk) begin
        if (loadctl == 4'd0) alu_a <= main_bus;
        if (loadctl == 4'd1) alu_b <= main_bus;
        if (calcfn) alu_f <= alu_out[11:8];
    end

    // Control word the spec table requires per phase, packed like the DUT outputs below.
    function automatic logic [23:0] exp_ctl(input int ph, input logic [2:0] op, input logic [1:0] sel,
                                            input logic ci, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] oc;
        logic [3:0] lc;
        logic [1:0] al;
        logic [2:0] ar;
        logic       cf;
        logic       c;
        logic       oe;
        logic [7:0] d;
        oc = 4'hF; lc = 4'hF; al = 2'd0; ar = 3'd6; cf = 1'b0; c = 1'b0; oe = 1'b0; d = 8'h00;
        case (ph)
            PH_LA:   begin lc = 4'd0; oe = 1'b1; d = a; end
            PH_LB:   begin lc = 4'd1; oe = 1'b1; d = b; end
            PH_CALC: begin oc = 4'd2; lc = 4'd0; ar = op; al = sel; c = ci; cf = 1'b1; end
            PH_READ: oc = 4'd0;
            default: ;
        endcase
        return {oc, lc, al, ar, cf, c, oe, d};
    endfunction

    logic [23:0] obs_ctl;
    assign obs_ctl = {outctl, loadctl, arg_l, arg_r, calcfn, cin, bus_oe, bus_data};

    task automatic scramble_cmd();
        cmd_op      = 3'($urandom_range(0, 7));
        cmd_sel_l   = 2'($urandom_range(0, 3));
        cmd_cin     = 1'($urandom_range(0, 1));
        cmd_use_acc = 1'($urandom_range(0, 1));
        cmd_a       = 8'($urandom);
        cmd_b       = 8'($urandom);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [1:0] sel, input logic ci,
                          input logic ua, input logic [7:0] a, input logic [7:0] b, input int stall);
        logic [7:0]  left;
        logic [11:0] r;
        logic [7:0]  exp_data;
        logic [3:0]  exp_flags;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        int          idx;
        int          w;
        int          ph[$];

        if (op == 3'd6) begin
            exp_data = 8'h00; exp_flags = 4'h0; exp_err = 1'b1; exp_lat = 1;
        end else begin
            case (sel)
                2'd0:    left = ua ? acc : a;
                2'd1:    left = b;
                2'd2:    left = 8'h00;
                default: left = 8'hFF;
            endcase
            r = alu_ref(op, left, b, ci);
            exp_data = r[7:0]; exp_flags = r[11:8]; exp_err = 1'b0;
            exp_lat = ua ? 4 : 5;
            if (!ua) ph.push_back(PH_LA);
            ph.push_back(PH_LB);
            ph.push_back(PH_CALC);
            ph.push_back(PH_READ);
        end

        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready wait: got %b want 1", name, cmd_ready);
        end

        cmd_valid = 1'b1; cmd_op = op; cmd_sel_l = sel; cmd_cin = ci; cmd_use_acc = ua;
        cmd_a = a; cmd_b = b;
        @(posedge clk);
        #1;
        // Keep offering junk while busy; it must be ignored.
        scramble_cmd();

        lat = 1;
        idx = 0;
        @(negedge clk);
        while (!res_valid && lat < 20) begin
            checks++;
            if (idx >= ph.size()) begin
                errors++;
                $display("FAIL %s extra busy cycle %0d: ctl %h res_valid %b", name, lat, obs_ctl, res_valid);
            end else if (obs_ctl !== exp_ctl(ph[idx], op, sel, ci, a, b) || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got ctl %h busy %b rdy %b want ctl %h busy 1 rdy 0",
                         name, lat, obs_ctl, busy, cmd_ready, exp_ctl(ph[idx], op, sel, ci, a, b));
            end
            @(negedge clk);
            lat++;
            idx++;
        end
        checks++;
        if (lat !== exp_lat || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d (res_valid %b) want %0d", name, lat, res_valid, exp_lat);
        end

        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_data || res_flags !== exp_flags || res_err !== exp_err) begin
                errors++;
                $display("FAIL %s result stall%0d: got v%b d%0d f%b e%b want v1 d%0d f%b e%b", name, s,
                         res_valid, res_data, res_flags, res_err, exp_data, exp_flags, exp_err);
            end
            checks++;
            if (obs_ctl !== exp_ctl(PH_IDLE, op, sel, ci, a, b) || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s done ctl stall%0d: got ctl %h rdy %b busy %b want ctl %h rdy 0 busy 1",
                         name, s, obs_ctl, cmd_ready, busy, exp_ctl(PH_IDLE, op, sel, ci, a, b));
            end
            if (s < stall) @(negedge clk);
        end

        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after handshake: got v%b busy%b rdy%b want v0 busy0 rdy1",
                     name, res_valid, busy, cmd_ready);
        end

        if (op != 3'd6) begin
            acc = exp_data;
            acc_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (obs_ctl !== exp_ctl(PH_IDLE, 3'd0, 2'd0, 1'b0, 8'h00, 8'h00) || res_valid !== 1'b0 ||
            res_data !== 8'h00 || res_flags !== 4'h0 || res_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset state: got ctl %h v%b d%0d f%b e%b busy%b want ctl f_f_0_6_0 all zero",
                     obs_ctl, res_valid, res_data, res_flags, res_err, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset release: got rdy %b busy %b want rdy 1 busy 0", cmd_ready, busy);
        end
    endtask

    task automatic test_full_add();
        run_op("full_add", 3'd1, 2'd0, 1'b0, 1'b0, 8'd24, 8'd18, 0);
        checks++;
        if (acc !== 8'd42) begin
            errors++;
            $display("FAIL full_add value: model acc %0d want 42", acc);
        end
    endtask

    task automatic test_acc_chain();
        run_op("acc_chain", 3'd1, 2'd0, 1'b0, 1'b1, 8'h5A, 8'd8, 1);
    endtask

    task automatic test_wrap();
        run_op("wrap", 3'd1, 2'd0, 1'b0, 1'b0, 8'd42, 8'd214, 0);
    endtask

    task automatic test_backpressure();
        run_op("backpressure", 3'd2, 2'd0, 1'b1, 1'b0, 8'd100, 8'd37, 10);
        run_op("after_stall", 3'd5, 2'd1, 1'b0, 1'b0, 8'h0F, 8'hF3, 0);
    endtask

    task automatic test_reserved_op();
        run_op("reserved_op", 3'd6, 2'd3, 1'b1, 1'b0, 8'hAA, 8'h55, 3);
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_sel_l = 2'd0; cmd_cin = 1'b0; cmd_use_acc = 1'b0;
        cmd_a = 8'd7; cmd_b = 8'd9;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outctl !== 4'd2 || calcfn !== 1'b1) begin
            errors++;
            $display("FAIL mid_calc setup: got outctl %h calcfn %b want 2 1", outctl, calcfn);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outctl !== 4'hF || loadctl !== 4'hF || arg_r !== 3'd6 || calcfn !== 1'b0 || bus_oe !== 1'b0 ||
            busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_calc async reset: got out %h ld %h r %0d cf %b oe %b busy %b v %b want f f 6 0 0 0 0",
                     outctl, loadctl, arg_r, calcfn, bus_oe, busy, res_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        acc_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_calc release: got rdy %b busy %b want 1 0", cmd_ready, busy);
        end
        run_op("post_reset_add", 3'd1, 2'd0, 1'b0, 1'b0, 8'd24, 8'd18, 0);
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic       ua;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            ua = acc_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op("random", op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ua,
                   8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        cmd_op = 3'd0; cmd_sel_l = 2'd0; cmd_cin = 1'b0; cmd_use_acc = 1'b0;
        cmd_a = 8'h00; cmd_b = 8'h00;
        acc = 8'h00;
        acc_valid = 1'b0;

        test_reset();
        test_full_add();
        test_acc_chain();
        test_wrap();
        test_backpressure();
        test_reserved_op();
        test_reset_mid_calc();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
